// File: rtl/pipeline_pkt_sequencer_pkg.sv
// Shared definitions for the packet pipeline sequencer and the pipeline it drives.
package pipeline_pkt_sequencer_pkg;

  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned THREAD_W    = $clog2(NUM_THREADS);

  localparam logic [THREAD_W-1:0] LAST_THREAD = THREAD_W'(NUM_THREADS - 1);

  localparam logic [1:0] MODE_WR   = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b10;
  localparam logic [1:0] MODE_RD   = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun,
    StDrain
  } seq_state_e;

endpackage

// File: rtl/pipeline_pkt_sequencer_thread_ctr.sv
// Round-robin thread counter: clear wins over enable, wraps after the last thread.
module pkt_rr_thread_ctr
  import pipeline_pkt_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                en_i,
  output logic [THREAD_W-1:0] thread_o
);

  logic [THREAD_W-1:0] thread_q, thread_d;

  always_comb begin
    thread_d = thread_q;
    if (clr_i) begin
      thread_d = '0;
    end else if (en_i) begin
      thread_d = thread_q + THREAD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      thread_q <= '0;
    end else begin
      thread_q <= thread_d;
    end
  end

  assign thread_o = thread_q;

endmodule

// File: rtl/pipeline_pkt_sequencer.sv
// Upstream control for the 4-thread packet pipeline: load one packet into the pipeline
// FIFO, run the threads round-robin, then drain the FIFO to the egress port.
module pipeline_pkt_sequencer
  import pipeline_pkt_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MAX_WORDS  = 256,
  parameter int unsigned RUN_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   FIFO_almost_FULL,
  input  logic [NUM_THREADS-1:0] thread_done,
  input  logic [DATA_W-1:0]      pkt_out,
  output logic [1:0]             mode_code,
  output logic [THREAD_W-1:0]    thread_IF,
  output logic [DATA_W-1:0]      pkt_in,
  output logic                   core_rst,
  output logic                   rst_FIFO,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   err_overflow
);

  localparam int unsigned WcntW = $clog2(MAX_WORDS) + 1;
  localparam int unsigned RcntW = $clog2(RUN_CYCLES);

  localparam logic [WcntW-1:0] MaxWords = WcntW'(MAX_WORDS);
  localparam logic [RcntW-1:0] RcntLast = RcntW'(RUN_CYCLES - 1);

  seq_state_e          state_q, state_d;
  logic [WcntW-1:0]    wcnt_q, wcnt_d;
  logic [WcntW-1:0]    rdcnt_q, rdcnt_d;
  logic [RcntW-1:0]    rcnt_q, rcnt_d;
  logic                err_q, err_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                rst_fifo_q;
  logic                accept;
  logic                thread_clr, thread_en;
  logic [THREAD_W-1:0] thread;

  pkt_rr_thread_ctr u_thread_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (thread_clr),
    .en_i     (thread_en),
    .thread_o (thread)
  );

  // Stretches the FIFO clear one cycle past reset release.
  always_ff @(posedge clk) begin
    rst_fifo_q <= rst;
  end

  assign rst_FIFO = rst | rst_fifo_q;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rdcnt_d     = rdcnt_q;
    rcnt_d      = rcnt_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    in_ready    = 1'b0;
    mode_code   = MODE_HOLD;
    pkt_in      = '0;
    core_rst    = 1'b1;
    thread_clr  = 1'b1;
    thread_en   = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      StIdle: in_ready = 1'b1;
      StFill: in_ready = ~FIFO_almost_FULL;
      StRun: begin
        core_rst   = 1'b0;
        mode_code  = MODE_RUN;
        thread_clr = 1'b0;
        thread_en  = 1'b1;
        // Leave only at a round boundary so every thread gets equal issue slots.
        if ((thread == LAST_THREAD) && ((&thread_done) || (rcnt_q == RcntLast))) begin
          state_d = StDrain;
        end else begin
          rcnt_d = rcnt_q + RcntW'(1);
        end
      end
      StDrain: begin
        if (rdcnt_q != wcnt_q) begin
          mode_code   = MODE_RD;
          rdcnt_d     = rdcnt_q + WcntW'(1);
          out_valid_d = 1'b1;
          out_last_d  = (rdcnt_d == wcnt_q);
        end
        if (out_valid_q && out_last_q) begin
          state_d = StIdle;
          wcnt_d  = '0;
          rcnt_d  = '0;
          rdcnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready = in_ready & ~rst_FIFO;
    accept   = in_valid & in_ready;

    if (accept) begin
      mode_code = MODE_WR;
      pkt_in    = in_data;
      wcnt_d    = wcnt_q + WcntW'(1);
      state_d   = (in_last || (wcnt_d == MaxWords)) ? StRun : StFill;
      if (!in_last && (wcnt_d == MaxWords)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      rdcnt_q     <= '0;
      rcnt_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rdcnt_q     <= rdcnt_d;
      rcnt_q      <= rcnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // pkt_out already lags the read by one cycle, so it is forwarded without another register.
  assign out_data     = out_valid_q ? pkt_out : '0;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign thread_IF    = thread;
  assign busy         = (state_q != StIdle);
  assign err_overflow = err_q;

endmodule

// File: tb/tb_pipeline_pkt_sequencer.sv
// Scoreboard bench for pipeline_pkt_sequencer with a behavioural pipeline FIFO model.
module tb_pipeline_pkt_sequencer;
  import pipeline_pkt_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        FIFO_almost_FULL = 1'b0;
  logic [3:0]  thread_done = '0;
  logic [63:0] pkt_out = '0;
  logic [1:0]  mode_code;
  logic [1:0]  thread_IF;
  logic [63:0] pkt_in;
  logic        core_rst, rst_FIFO, out_valid, out_last, busy, err_overflow;
  logic [63:0] out_data;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } eg_t;

  logic [63:0] wr_q[$];
  eg_t         eg_q[$];
  logic [63:0] fifo_m[$];
  int          n_chk = 0;
  int          n_fail = 0;

  pipeline_pkt_sequencer #(
    .DATA_W     (64),
    .MAX_WORDS  (256),
    .RUN_CYCLES (64)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_last          (in_last),
    .in_ready         (in_ready),
    .FIFO_almost_FULL (FIFO_almost_FULL),
    .thread_done      (thread_done),
    .pkt_out          (pkt_out),
    .mode_code        (mode_code),
    .thread_IF        (thread_IF),
    .pkt_in           (pkt_in),
    .core_rst         (core_rst),
    .rst_FIFO         (rst_FIFO),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_last         (out_last),
    .busy             (busy),
    .err_overflow     (err_overflow)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Pipeline FIFO model: write on mode 00, read data appears one cycle after mode 01.
  always @(posedge clk) begin
    if (rst_FIFO) begin
      fifo_m.delete();
    end else begin
      if (mode_code == 2'b00) fifo_m.push_back(pkt_in);
      if (mode_code == 2'b01) begin
        if (fifo_m.size() > 0) pkt_out <= fifo_m.pop_front();
        else pkt_out <= 'x;
      end
    end
  end

  // Monitor: every FIFO write and every egress word must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (mode_code == 2'b00) begin
        if (wr_q.size() == 0) check("unexpected_fifo_write", pkt_in, 64'hx);
        else check("pkt_in", pkt_in, wr_q.pop_front());
      end
      if (out_valid) begin
        if (eg_q.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          eg_t e;
          e = eg_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", 64'(out_last), 64'(e.last));
        end
      end
    end
  end

  task automatic send_pkt(input int n, input logic [63:0] base, input int stall_at,
                          input bit expect_eg, input bit has_last);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      logic [63:0] w;
      logic        lst;
      int          t;
      w   = base + 64'(i);
      lst = has_last && (i == n - 1);
      in_valid = 1'b1;
      in_data  = w;
      in_last  = lst;
      if (i == stall_at) begin
        FIFO_almost_FULL = 1'b1;
        repeat (2) begin
          @(negedge clk);
          check("afull_in_ready", 64'(in_ready), 64'd0);
          check("afull_mode", 64'(mode_code), 64'(MODE_HOLD));
          @(posedge clk);
          #1;
        end
        FIFO_almost_FULL = 1'b0;
      end
      wr_q.push_back(w);
      if (expect_eg) eg_q.push_back('{data: w, last: lst});
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
        t++;
        @(negedge clk);
      end
      if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // done_from < 0 keeps thread_done low; returns at the negedge of the first non-RUN cycle.
  task automatic run_phase(input int done_from, input int exp_cycles);
    int k;
    bit in_run;
    k      = 0;
    in_run = 1'b1;
    while (in_run && k < 200) begin
      thread_done = (done_from >= 0 && k >= done_from) ? 4'hF : 4'h0;
      @(negedge clk);
      if (mode_code != MODE_RUN) begin
        in_run = 1'b0;
      end else begin
        check("run_thread_if", 64'(thread_IF), 64'(k % 4));
        if (k == 0) check("run_core_rst", 64'(core_rst), 64'd0);
        k++;
        @(posedge clk);
        #1;
      end
    end
    thread_done = 4'h0;
    check("run_cycles", 64'(k), 64'(exp_cycles));
    check("drain_first_mode", 64'(mode_code), 64'(MODE_RD));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (eg_q.size() != 0 && t < 700) begin
      @(posedge clk);
      t++;
    end
    check("drain_complete", 64'(eg_q.size()), 64'd0);
    @(negedge clk);
    check("busy_after_drain", 64'(busy), 64'd0);
    check("mode_after_drain", 64'(mode_code), 64'(MODE_HOLD));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rst_fifo", 64'(rst_FIFO), 64'd1);
    check("rst_mode", 64'(mode_code), 64'(MODE_HOLD));
    check("rst_thread_if", 64'(thread_IF), 64'd0);
    check("rst_pkt_in", pkt_in, 64'd0);
    check("rst_core_rst", 64'(core_rst), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_overflow), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_rst_fifo", 64'(rst_FIFO), 64'd1);
    check("post_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("idle_rst_fifo", 64'(rst_FIFO), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // 3 words, all threads halt from RUN cycle 2: one full round then drain.
    send_pkt(3, 64'hA5A5_0000_0000_0010, -1, 1'b1, 1'b1);
    run_phase(1, 4);
    wait_drain();

    // 3 words, threads never halt: full budget of 64 RUN cycles.
    send_pkt(3, 64'h1234_5678_9ABC_0000, -1, 1'b1, 1'b1);
    run_phase(-1, 64);
    wait_drain();

    // 5 words with the FIFO almost-full for two cycles before word 2.
    send_pkt(5, 64'hC0DE_0000_0000_0100, 2, 1'b1, 1'b1);
    run_phase(0, 4);
    wait_drain();

    // Overflow: 256 words without in_last, then word 257 must be held off.
    check("err_before_overflow", 64'(err_overflow), 64'd0);
    send_pkt(256, 64'h0F00_0000_0000_0000, -1, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 64'hDEAD_BEEF_0000_0101;
    in_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("ovf_err", 64'(err_overflow), 64'd1);
      check("ovf_in_ready", 64'(in_ready), 64'd0);
      check("ovf_mode_run", 64'(mode_code), 64'(MODE_RUN));
      @(posedge clk);
      #1;
    end

    // Reset in the middle of RUN.
    rst      = 1'b1;
    in_valid = 1'b0;
    wr_q.delete();
    eg_q.delete();
    @(negedge clk);
    check("midrun_rst_fifo", 64'(rst_FIFO), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_rst_fifo", 64'(rst_FIFO), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_mode", 64'(mode_code), 64'(MODE_HOLD));
    check("abort_core_rst", 64'(core_rst), 64'd1);
    check("abort_err", 64'(err_overflow), 64'd0);
    check("abort_thread_if", 64'(thread_IF), 64'd0);
    @(negedge clk);
    check("abort_idle_rst_fifo", 64'(rst_FIFO), 64'd0);
    check("abort_idle_in_ready", 64'(in_ready), 64'd1);

    check("wr_q_empty", 64'(wr_q.size()), 64'd0);
    check("eg_q_empty", 64'(eg_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
